// File: rtl/wb_dual_macro_splitter.sv
// Wishbone splitter: routes host accesses to one of two macro slaves, a local
// status window, or an error responder. Every access is bounded by a wait
// timeout so the host bus can never hang on a silent macro.
module wb_dual_macro_splitter #(
    parameter logic [31:0] BASE0     = 32'h3000_0000,
    parameter logic [31:0] BASE1     = 32'h3000_1000,
    parameter logic [31:0] STAT_BASE = 32'h3000_2000,
    parameter logic [31:0] WIN_MASK  = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m0_cyc_o,
    output logic        m0_stb_o,
    input  logic        m0_ack_i,
    input  logic [31:0] m0_dat_i,
    output logic        m1_cyc_o,
    output logic        m1_stb_o,
    input  logic        m1_ack_i,
    input  logic [31:0] m1_dat_i,
    output logic        timeout_irq_o
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // The counter starts at 0 on entry to BUSY, so TIMEOUT-1 is the last
    // cycle the macro is given before the access is abandoned.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RESP} state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [15:0]         err_cnt;
    logic [15:0]         timeout_cnt;
    logic [31:0]         last_err_adr;

    logic [31:0] win;
    logic [31:0] offset;
    logic        hit0;
    logic        hit1;
    logic        hit_stat;
    logic [31:0] stat_word;
    logic        sel_ack;
    logic [31:0] sel_dat;

    assign win      = wbs_adr_i & WIN_MASK;
    assign offset   = wbs_adr_i & ~WIN_MASK;
    assign hit0     = (win == BASE0);
    assign hit1     = (win == BASE1);
    assign hit_stat = (win == STAT_BASE);

    // Only the macro owning the current transaction is listened to.
    assign sel_ack = (state == BUSY0) ? m0_ack_i : m1_ack_i;
    assign sel_dat = (state == BUSY0) ? m0_dat_i : m1_dat_i;

    // Status window read mux; unknown offsets read as zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves stat_word unassigned (no latch).
        stat_word = 32'h0;
        case (offset)
            32'h0:   stat_word = {err_cnt, timeout_cnt};
            32'h4:   stat_word = last_err_adr;
            default: stat_word = 32'h0;
        endcase
    end

    // Transaction FSM with registered request, response and status state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state         <= IDLE;
            wait_cnt      <= '0;
            err_cnt       <= '0;
            timeout_cnt   <= '0;
            last_err_adr  <= '0;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            m_adr_o       <= '0;
            m_dat_o       <= '0;
            m_sel_o       <= '0;
            m_we_o        <= 1'b0;
            m0_cyc_o      <= 1'b0;
            m0_stb_o      <= 1'b0;
            m1_cyc_o      <= 1'b0;
            m1_stb_o      <= 1'b0;
            timeout_irq_o <= 1'b0;
        end else begin
            // Response and interrupt are single-cycle pulses by default.
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            timeout_irq_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        m_adr_o  <= wbs_adr_i;
                        m_dat_o  <= wbs_dat_i;
                        m_sel_o  <= wbs_sel_i;
                        m_we_o   <= wbs_we_i;
                        wait_cnt <= '0;
                        if (hit0) begin
                            m0_cyc_o <= 1'b1;
                            m0_stb_o <= 1'b1;
                            state    <= BUSY0;
                        end else if (hit1) begin
                            m1_cyc_o <= 1'b1;
                            m1_stb_o <= 1'b1;
                            state    <= BUSY1;
                        end else if (hit_stat) begin
                            state     <= RESP;
                            wbs_ack_o <= 1'b1;
                            if (wbs_we_i) begin
                                // Only the counter register is writable (clear on any write).
                                if (offset == 32'h0) begin
                                    err_cnt     <= '0;
                                    timeout_cnt <= '0;
                                end
                            end else begin
                                wbs_dat_o <= stat_word;
                            end
                        end else begin
                            state        <= RESP;
                            wbs_ack_o    <= 1'b1;
                            wbs_dat_o    <= ERR_DATA;
                            last_err_adr <= wbs_adr_i;
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
                    end
                end

                BUSY0, BUSY1: begin
                    if (!wbs_cyc_i) begin
                        // Host abandoned the cycle: release the macro silently.
                        m0_cyc_o <= 1'b0;
                        m0_stb_o <= 1'b0;
                        m1_cyc_o <= 1'b0;
                        m1_stb_o <= 1'b0;
                        state    <= IDLE;
                    end else if (sel_ack) begin
                        // Ack is checked before the terminal count so it wins a tie.
                        m0_cyc_o  <= 1'b0;
                        m0_stb_o  <= 1'b0;
                        m1_cyc_o  <= 1'b0;
                        m1_stb_o  <= 1'b0;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= sel_dat;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        m0_cyc_o      <= 1'b0;
                        m0_stb_o      <= 1'b0;
                        m1_cyc_o      <= 1'b0;
                        m1_stb_o      <= 1'b0;
                        wbs_ack_o     <= 1'b1;
                        wbs_dat_o     <= ERR_DATA;
                        timeout_irq_o <= 1'b1;
                        last_err_adr  <= m_adr_o;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // Ack is visible this cycle; a new request is sampled only once back in IDLE.
                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dual_macro_splitter.sv
// Directed bench for wb_dual_macro_splitter: behavioural macro slaves, a host
// task driving single accesses, and a queue of expected read words.
module tb_wb_dual_macro_splitter;

    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m0_cyc_o, m0_stb_o, m1_cyc_o, m1_stb_o;
    logic        m0_ack_i = 1'b0;
    logic        m1_ack_i = 1'b0;
    logic [31:0] m0_dat_i = 32'h0;
    logic [31:0] m1_dat_i = 32'h0;
    logic        timeout_irq_o;

    wb_dual_macro_splitter dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .m_adr_o       (m_adr_o),
        .m_dat_o       (m_dat_o),
        .m_sel_o       (m_sel_o),
        .m_we_o        (m_we_o),
        .m0_cyc_o      (m0_cyc_o),
        .m0_stb_o      (m0_stb_o),
        .m0_ack_i      (m0_ack_i),
        .m0_dat_i      (m0_dat_i),
        .m1_cyc_o      (m1_cyc_o),
        .m1_stb_o      (m1_stb_o),
        .m1_ack_i      (m1_ack_i),
        .m1_dat_i      (m1_dat_i),
        .timeout_irq_o (timeout_irq_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Macro behaviour, set by the stimulus: ack delay in cycles after stb rises
    // (negative = never), read data, and a forced stray ack.
    int          delay0 = -1, delay1 = -1;
    logic [31:0] data0 = 32'h0, data1 = 32'h0;
    logic        late0 = 1'b0;
    int          cnt0 = 0, cnt1 = 0;

    always @(posedge clk) begin
        #1;
        if (m0_stb_o) cnt0++; else cnt0 = 0;
        if (m1_stb_o) cnt1++; else cnt1 = 0;
        m0_ack_i = (m0_stb_o && delay0 >= 0 && cnt0 == delay0 + 1) || late0;
        m1_ack_i = (m1_stb_o && delay1 >= 0 && cnt1 == delay1 + 1);
        m0_dat_i = data0;
        m1_dat_i = data1;
    end

    // Activity counters, read as before/after deltas by the stimulus.
    int ack_cycles = 0, irq_cycles = 0, m0_cyc_cycles = 0, m1_cyc_cycles = 0, m0_stb_cycles = 0;

    always @(posedge clk) begin
        #1;
        if (wbs_ack_o)     ack_cycles++;
        if (timeout_irq_o) irq_cycles++;
        if (m0_cyc_o)      m0_cyc_cycles++;
        if (m1_cyc_o)      m1_cyc_cycles++;
        if (m0_stb_o)      m0_stb_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One host access; checks the latched request, latency, response word and
    // that ack is a single-cycle pulse followed by zero data.
    task automatic bus_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic w, input logic chk_dat,
                              input logic [31:0] exp_dat, input int exp_lat);
        int lat;
        logic [31:0] e;
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back(exp_dat);
        @(posedge clk); #1;
        lat = 1;
        stb = 1'b0;
        check({tag, "_madr"}, m_adr_o, a);
        check({tag, "_mdat"}, m_dat_o, d);
        check({tag, "_msel"}, {28'h0, m_sel_o}, {28'h0, s});
        check({tag, "_mwe"},  {31'h0, m_we_o}, {31'h0, w});
        while (!wbs_ack_o && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        cyc = 1'b0;
        check({tag, "_ack"}, {31'h0, wbs_ack_o}, 32'h1);
        e = exp_q.pop_front();
        if (chk_dat) check({tag, "_dat"}, wbs_dat_o, e);
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        check({tag, "_ack_low"}, {31'h0, wbs_ack_o}, 32'h0);
        check({tag, "_dat_low"}, wbs_dat_o, 32'h0);
    endtask

    initial begin
        int a0, i0, m0c, m1c, s0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",  {31'h0, wbs_ack_o}, 32'h0);
        check("rst_dat",  wbs_dat_o, 32'h0);
        check("rst_madr", m_adr_o, 32'h0);
        check("rst_strb", {28'h0, m0_cyc_o, m0_stb_o, m1_cyc_o, m1_stb_o}, 32'h0);
        check("rst_irq",  {31'h0, timeout_irq_o}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Macro 0 read, acks 3 cycles after stb
        delay0 = 3; data0 = 32'h1234_5678;
        m1c = m1_cyc_cycles;
        bus_access("m0_rd", 32'h3000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 5);
        check("m0_rd_m1_idle", m1_cyc_cycles - m1c, 0);

        // Macro 1 write, acks 2 cycles after stb
        delay1 = 2; data1 = 32'h0BAD_F00D;
        m0c = m0_cyc_cycles; a0 = ack_cycles;
        bus_access("m1_wr", 32'h3000_1008, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, 32'h0BAD_F00D, 4);
        check("m1_wr_m0_idle", m0_cyc_cycles - m0c, 0);
        check("m1_wr_one_ack", ack_cycles - a0, 1);

        // Unmapped access, then status readback
        bus_access("unmap", 32'h3000_5000, 32'h0, 4'hF, 1'b0, 1'b1, ERR_DATA, 1);
        bus_access("st_cnt", 32'h3000_2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0001_0000, 1);
        bus_access("st_lea", 32'h3000_2004, 32'h0, 4'hF, 1'b0, 1'b1, 32'h3000_5000, 1);
        bus_access("st_oth", 32'h3000_2008, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1);
        // Write to last_err_adr is ignored; write to counters clears them
        bus_access("st_wlea", 32'h3000_2004, 32'h1111_1111, 4'hF, 1'b1, 1'b0, 32'h0, 1);
        bus_access("st_lea2", 32'h3000_2004, 32'h0, 4'hF, 1'b0, 1'b1, 32'h3000_5000, 1);
        bus_access("st_clr", 32'h3000_2000, 32'h1234_0000, 4'hF, 1'b1, 1'b0, 32'h0, 1);
        bus_access("st_cnt0", 32'h3000_2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1);

        // Macro 0 never acks: timeout after TIMEOUT stb cycles
        delay0 = -1;
        s0 = m0_stb_cycles; i0 = irq_cycles;
        bus_access("tmo", 32'h3000_0020, 32'h0, 4'hF, 1'b0, 1'b1, ERR_DATA, TIMEOUT + 1);
        check("tmo_stb_cycles", m0_stb_cycles - s0, TIMEOUT);
        check("tmo_irq_once", irq_cycles - i0, 1);
        // Late ack from macro 0 must not produce a response
        a0 = ack_cycles;
        @(negedge clk); late0 = 1'b1;
        @(negedge clk); late0 = 1'b0;
        repeat (4) @(negedge clk);
        check("late_no_ack", ack_cycles - a0, 0);
        bus_access("tmo_cnt", 32'h3000_2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0000_0001, 1);
        bus_access("tmo_lea", 32'h3000_2004, 32'h0, 4'hF, 1'b0, 1'b1, 32'h3000_0020, 1);

        // Host abort two cycles into BUSY1
        delay1 = -1;
        a0 = ack_cycles;
        @(negedge clk);
        adr = 32'h3000_1040; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("abort_m1_up", {31'h0, m1_cyc_o}, 32'h1);
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk); cyc = 1'b0;
        @(posedge clk); #1;
        check("abort_m1_drop", {30'h0, m1_cyc_o, m1_stb_o}, 32'h0);
        repeat (4) @(negedge clk);
        check("abort_no_ack", ack_cycles - a0, 0);
        bus_access("abort_cnt", 32'h3000_2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0000_0001, 1);
        bus_access("clr2", 32'h3000_2000, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1);
        bus_access("clr2_cnt", 32'h3000_2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1);

        // Reset while in BUSY0
        delay0 = -1;
        @(negedge clk);
        adr = 32'h3000_0030; we = 1'b1; wdat = 32'h5555_AAAA; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("rstb_m0_up", {31'h0, m0_cyc_o}, 32'h1);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("rstb_strb", {28'h0, m0_cyc_o, m0_stb_o, m1_cyc_o, m1_stb_o}, 32'h0);
        check("rstb_ack",  {31'h0, wbs_ack_o}, 32'h0);
        check("rstb_madr", m_adr_o, 32'h0);
        check("rstb_mdat", m_dat_o, 32'h0);
        check("rstb_we",   {31'h0, m_we_o}, 32'h0);
        @(negedge clk); rst = 1'b0;
        delay0 = 1; data0 = 32'hCAFE_0001;
        bus_access("post_rst", 32'h3000_0030, 32'h0, 4'h3, 1'b0, 1'b1, 32'hCAFE_0001, 3);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
